axi4l_csr_bank: RTL and testbench
=================================

AXI4L_CSR_BANK -- requirements
Module: axi4l_csr_bank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0.
REQ-002 SHALL have parameter RW_CNT, default 4, number of read/write control registers (1..64).
REQ-003 SHALL have parameter RO_CNT, default 2, number of read-only status registers (0..64), mapped after the RW registers.
REQ-004 SHALL have parameter SHADOW_EN, default 1, enabling double-buffered (shadowed) control outputs.
REQ-005 SHALL have parameter RST_VAL, default all zero, packed RW_CNT x 32 reset values of the RW registers.
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_n_i  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 csr_i  axi4_lite_if.slave  32-bit addr/data  AXI4-Lite CSR port.
REQ-009 upd_i  input  1  shadow update strobe (e.g. start of frame); one-cycle pulse.
REQ-010 status_i  input  RO_CNT x 32  live status values.
REQ-011 ctrl_o  output  RW_CNT x 32  active control register values.
REQ-012 wr_pulse_o  output  RW_CNT  one-cycle pulse per RW register on a committed write.

Function
REQ-013 Register index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored; index < RW_CNT is RW, RW_CNT..RW_CNT+RO_CNT-1 is RO, anything else (incl. addr < BASE_ADDR) is unmapped.
REQ-014 AW and W SHALL be accepted independently in any order; each is latched in its own holding register, and its ready deasserts once latched until the B handshake completes.
REQ-015 Write SHALL commit on the first clock edge at which both AW and W holding registers are full; bvalid rises on that same edge, and the holding registers clear.
REQ-016 Commit SHALL apply byte lane n only when wstrb[n]=1; wstrb=0 commits nothing but still returns OKAY.
REQ-017 bresp SHALL be OKAY (2'b00) for RW targets and SLVERR (2'b10) for RO or unmapped targets, which leave all state unchanged and pulse nothing.
REQ-018 bvalid SHALL hold until bready; awready/wready stay low while bvalid=1 (one outstanding write).
REQ-019 arready SHALL be high whenever rvalid=0; read data is registered with exactly 1-cycle latency after the AR handshake.
REQ-020 RW reads SHALL return the staging value, RO reads the status_i sample at the AR handshake, unmapped reads 32'd0 with rresp SLVERR.
REQ-021 rvalid/rdata SHALL hold stable until rready; read and write paths operate concurrently without interference.
REQ-022 With SHADOW_EN=1, ctrl_o SHALL load all staging registers on the edge where upd_i=1; a write committing on the same edge is not seen until the next upd_i.
REQ-023 With SHADOW_EN=0, ctrl_o SHALL equal the staging registers directly (visible the cycle after commit).
REQ-024 wr_pulse_o[i] SHALL be high for exactly the cycle after a committed write to register i with nonzero wstrb.

Reset
REQ-025 While rst_n_i=0: staging and ctrl_o = RST_VAL; bvalid, rvalid, wr_pulse_o = 0; rdata = 0; holding registers empty; awready/wready/arready = 1 after release.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no commit and no response.

Structure
REQ-027 Address/response constants (RESP_OKAY, RESP_SLVERR) and the register-index type SHALL live in shared package axi4l_csr_bank_pkg; block-specific register maps stay in their own packages and instantiate this block.
REQ-028 Optional single sub-module axi4l_csr_decode (combinational address-to-index/class decoder), used once for reads and once for writes.

Verification
REQ-029 W before AW by 3 cycles to reg 1, wdata 32'hA5A5_0001, wstrb 4'hF -> single bvalid, bresp 00, readback A5A5_0001, wr_pulse_o[1] one cycle.
REQ-030 wstrb 4'b0010, wdata 32'h0000_BB00 over reg 0 = 32'h1122_3344 -> readback 32'h1122_BB44.
REQ-031 Write to RO index RW_CNT and to BASE_ADDR+0x100 -> bresp 10, no state change; read of 0x100 -> rdata 0, rresp 10.
REQ-032 SHADOW_EN=1: write reg 2 = 7, ctrl_o[2] unchanged; upd_i coinciding with commit -> still old; next upd_i -> 7.
REQ-033 bready held low 10 cycles -> bvalid stable, awready/wready low; concurrent read of reg 0 completes with 1-cycle latency.
REQ-034 rst_n_i pulsed low between AW and W -> no commit, no bvalid, ctrl_o = RST_VAL.

Source files
------------

// File: rtl/axi4l_csr_bank_pkg.sv
// Shared definitions for the AXI4-Lite CSR bank: response codes, the
// register-index type, the address-class enum and the byte-lane merge helper.
package axi4l_csr_bank_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Wide enough for 64 RW + 64 RO registers.
  localparam int IDX_W = 7;
  typedef logic [IDX_W-1:0] csr_idx_t;

  typedef enum logic [1:0] {
    CSR_RW       = 2'd0,
    CSR_RO       = 2'd1,
    CSR_UNMAPPED = 2'd2
  } csr_class_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle (32-bit address and data). The slave modport is used by
// the CSR bank; the master modport by whatever drives it.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_csr_decode.sv
// Combinational address decoder for the CSR bank.
//   i_addr : byte address from AW or AR
//   o_idx  : register index, (addr - BASE_ADDR) >> 2
//   o_cls  : RW, RO or UNMAPPED (below BASE_ADDR or past the last register)
module axi4l_csr_decode
  import axi4l_csr_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RW_CNT    = 4,
  parameter int          RO_CNT    = 2
) (
  input  logic [31:0] i_addr,
  output csr_idx_t    o_idx,
  output csr_class_t  o_cls
);

  localparam logic [32:0] MAP_BYTES = 33'((RW_CNT + RO_CNT) * 4);

  logic [31:0] w_offset;
  logic        w_below;
  logic        w_in_range;

  assign w_offset   = i_addr - BASE_ADDR;
  assign w_below    = (i_addr < BASE_ADDR);
  // Full-width compare so a large offset never aliases onto a small index.
  assign w_in_range = ({1'b0, w_offset} < MAP_BYTES);
  assign o_idx      = w_offset[IDX_W+1:2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_cls = CSR_UNMAPPED;
    if (!w_below && w_in_range) begin
      o_cls = (o_idx < IDX_W'(RW_CNT)) ? CSR_RW : CSR_RO;
    end
  end

endmodule

// File: rtl/axi4l_csr_bank.sv
// AXI4-Lite control/status register bank.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   csr_i          : AXI4-Lite slave port, one outstanding write, one outstanding read
//   upd_i          : shadow update strobe; copies staging into ctrl_o (SHADOW_EN=1)
//   status_i       : RO_CNT live status words, sampled at the AR handshake
//   ctrl_o         : RW_CNT active control words
//   wr_pulse_o     : one-cycle pulse per RW register after a committed write
// RW registers occupy indices 0..RW_CNT-1, RO registers follow; everything else
// answers SLVERR.
module axi4l_csr_bank
  import axi4l_csr_bank_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
  parameter int                   RW_CNT    = 4,
  parameter int                   RO_CNT    = 2,
  parameter bit                   SHADOW_EN = 1'b1,
  parameter logic [RW_CNT*32-1:0] RST_VAL   = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  axi4_lite_if.slave                             csr_i,
  input  logic                                   upd_i,
  input  logic [((RO_CNT > 0) ? RO_CNT : 1)*32-1:0] status_i,
  output logic [RW_CNT*32-1:0]                   ctrl_o,
  output logic [RW_CNT-1:0]                      wr_pulse_o
);

  // Write holding registers
  logic        r_aw_full;
  logic [31:0] r_aw_addr;
  logic        r_w_full;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;

  // Response and read channels
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  // Staging registers (what software reads back) and write pulses
  logic [31:0]       r_stage [RW_CNT];
  logic [RW_CNT-1:0] r_wr_pulse;

  csr_idx_t   w_wr_idx, w_rd_idx;
  csr_class_t w_wr_cls, w_rd_cls;
  logic       w_aw_hs, w_w_hs, w_ar_hs;
  logic       w_commit, w_commit_rw;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  // Channels stay closed while a response is pending: one outstanding write.
  assign csr_i.awready = !r_aw_full && !r_bvalid;
  assign csr_i.wready  = !r_w_full && !r_bvalid;
  assign csr_i.bvalid  = r_bvalid;
  assign csr_i.bresp   = r_bresp;
  assign csr_i.arready = !r_rvalid;
  assign csr_i.rvalid  = r_rvalid;
  assign csr_i.rdata   = r_rdata;
  assign csr_i.rresp   = r_rresp;

  assign w_aw_hs     = csr_i.awvalid && csr_i.awready;
  assign w_w_hs      = csr_i.wvalid && csr_i.wready;
  assign w_ar_hs     = csr_i.arvalid && csr_i.arready;
  assign w_commit    = r_aw_full && r_w_full;
  assign w_commit_rw = w_commit && (w_wr_cls == CSR_RW);

  axi4l_csr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .RW_CNT    (RW_CNT),
    .RO_CNT    (RO_CNT)
  ) u_wr_decode (
    .i_addr (r_aw_addr),
    .o_idx  (w_wr_idx),
    .o_cls  (w_wr_cls)
  );

  axi4l_csr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .RW_CNT    (RW_CNT),
    .RO_CNT    (RO_CNT)
  ) u_rd_decode (
    .i_addr (csr_i.araddr),
    .o_idx  (w_rd_idx),
    .o_cls  (w_rd_cls)
  );

  // Holding-register occupancy and the B channel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= (w_wr_cls == CSR_RW) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs) r_aw_full <= 1'b1;
      if (w_w_hs)  r_w_full  <= 1'b1;
      if (r_bvalid && csr_i.bready) r_bvalid <= 1'b0;
    end
  end

  // NOTE: holding address/data carry no reset; they are only consumed when the matching full flag is set.
  always_ff @(posedge clk_i) begin
    if (w_aw_hs) r_aw_addr <= csr_i.awaddr;
    if (w_w_hs) begin
      r_w_data <= csr_i.wdata;
      r_w_strb <= csr_i.wstrb;
    end
  end

  // Staging registers and per-register write pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RW_CNT; i++) r_stage[i] <= RST_VAL[i*32 +: 32];
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int i = 0; i < RW_CNT; i++) begin
        if (w_commit_rw && (w_wr_idx == IDX_W'(i))) begin
          r_stage[i]    <= apply_strb(r_stage[i], r_w_data, r_w_strb);
          r_wr_pulse[i] <= |r_w_strb;
        end
      end
    end
  end

  assign wr_pulse_o = r_wr_pulse;

  // Read data source, resolved at the AR handshake.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_SLVERR;
    case (w_rd_cls)
      CSR_RW: begin
        w_rd_resp = RESP_OKAY;
        for (int i = 0; i < RW_CNT; i++) begin
          if (w_rd_idx == IDX_W'(i)) w_rd_data = r_stage[i];
        end
      end
      CSR_RO: begin
        w_rd_resp = RESP_OKAY;
        for (int j = 0; j < RO_CNT; j++) begin
          if (w_rd_idx == IDX_W'(RW_CNT + j)) w_rd_data = status_i[j*32 +: 32];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && csr_i.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Active control outputs.
  if (SHADOW_EN) begin : g_shadow
    logic [31:0] r_ctrl [RW_CNT];

    // Takes the pre-edge staging value, so a write committing on the same
    // edge as upd_i waits for the next update.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < RW_CNT; i++) r_ctrl[i] <= RST_VAL[i*32 +: 32];
      end else if (upd_i) begin
        for (int i = 0; i < RW_CNT; i++) r_ctrl[i] <= r_stage[i];
      end
    end

    for (genvar i = 0; i < RW_CNT; i++) begin : g_out
      assign ctrl_o[i*32 +: 32] = r_ctrl[i];
    end
  end else begin : g_direct
    for (genvar i = 0; i < RW_CNT; i++) begin : g_out
      assign ctrl_o[i*32 +: 32] = r_stage[i];
    end
  end

endmodule

// File: tb/tb_axi4l_csr_bank.sv
// Self-checking bench for axi4l_csr_bank: directed scenarios plus randomized
// traffic, all compared against an address-arithmetic reference model.
module tb_axi4l_csr_bank;
  import axi4l_csr_bank_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          RW   = 4;
  localparam int          RO   = 2;
  localparam logic [RW*32-1:0] RST = {32'hDEAD_0003, 32'h0000_0002, 32'hCAFE_0001, 32'h1234_5678};

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              upd = 1'b0;
  logic [RO*32-1:0]  status = '0;
  logic [RW*32-1:0]  ctrl;
  logic [RW-1:0]     pulse;

  axi4_lite_if u_axi ();

  axi4l_csr_bank #(
    .BASE_ADDR (BASE),
    .RW_CNT    (RW),
    .RO_CNT    (RO),
    .SHADOW_EN (1'b1),
    .RST_VAL   (RST)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .csr_i      (u_axi),
    .upd_i      (upd),
    .status_i   (status),
    .ctrl_o     (ctrl),
    .wr_pulse_o (pulse)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_stage [RW];
  logic [31:0] m_ctrl  [RW];

  function automatic void m_reset();
    for (int i = 0; i < RW; i++) begin
      m_stage[i] = RST[i*32 +: 32];
      m_ctrl[i]  = RST[i*32 +: 32];
    end
  endfunction

  function automatic longint m_index(input logic [31:0] addr);
    if (addr < BASE) return -1;
    return (longint'(addr) - longint'(BASE)) / 4;
  endfunction

  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb, output logic [RW-1:0] pexp);
    longint idx;
    idx  = m_index(addr);
    pexp = '0;
    if (idx >= 0 && idx < RW) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_stage[int'(idx)][8*b +: 8] = data[8*b +: 8];
      if (strb != 4'h0) pexp[int'(idx)] = 1'b1;
      return RESP_OKAY;
    end
    return RESP_SLVERR;
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp);
    longint idx;
    idx = m_index(addr);
    if (idx >= 0 && idx < RW) begin
      data = m_stage[int'(idx)]; resp = RESP_OKAY;
    end else if (idx >= RW && idx < RW + RO) begin
      data = status[int'(idx - RW)*32 +: 32]; resp = RESP_OKAY;
    end else begin
      data = '0; resp = RESP_SLVERR;
    end
  endfunction

  function automatic void m_update();
    for (int i = 0; i < RW; i++) m_ctrl[i] = m_stage[i];
  endfunction

  function automatic logic [RW*32-1:0] m_ctrl_packed();
    logic [RW*32-1:0] v;
    for (int i = 0; i < RW; i++) v[i*32 +: 32] = m_ctrl[i];
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return BASE + 32'(4 * $urandom_range(0, RW + RO - 1)) + 32'($urandom_range(0, 3));
    if (r == 7) return BASE + 32'(4 * $urandom_range(RW + RO, 60));
    if (r == 8) return BASE - 32'(4 * $urandom_range(1, 4));
    return $urandom;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_aw(input logic [31:0] addr);
    int cnt = 0;
    u_axi.awaddr = addr; u_axi.awvalid = 1'b1;
    while (!u_axi.awready && cnt < 50) begin tick(1); cnt++; end
    if (!u_axi.awready) begin
      n_total++; $display("FAIL aw_timeout: awready=%b, required 1", u_axi.awready);
    end
    tick(1);
    u_axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int cnt = 0;
    u_axi.wdata = data; u_axi.wstrb = strb; u_axi.wvalid = 1'b1;
    while (!u_axi.wready && cnt < 50) begin tick(1); cnt++; end
    if (!u_axi.wready) begin
      n_total++; $display("FAIL w_timeout: wready=%b, required 1", u_axi.wready);
    end
    tick(1);
    u_axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr);
    int cnt = 0;
    u_axi.araddr = addr; u_axi.arvalid = 1'b1;
    while (!u_axi.arready && cnt < 50) begin tick(1); cnt++; end
    if (!u_axi.arready) begin
      n_total++; $display("FAIL ar_timeout: arready=%b, required 1", u_axi.arready);
    end
    tick(1);
    u_axi.arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic [RW-1:0] p0, output logic [RW-1:0] p1);
    int cnt = 0;
    u_axi.bready = 1'b1;
    while (!u_axi.bvalid && cnt < 50) begin tick(1); cnt++; end
    if (!u_axi.bvalid) begin
      n_total++; $display("FAIL b_timeout: bvalid=%b, required 1", u_axi.bvalid);
      resp = 2'bxx; p0 = 'x; p1 = 'x;
      u_axi.bready = 1'b0;
      return;
    end
    resp = u_axi.bresp;
    p0   = pulse;
    tick(1);
    p1   = pulse;
    u_axi.bready = 1'b0;
  endtask

  // mode 0: AW then W, mode 1: W then AW, mode 2: both together
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, output logic [1:0] resp,
                          output logic [RW-1:0] p0, output logic [RW-1:0] p1);
    int  cnt = 0;
    logic a_rdy, w_rdy;
    case (mode)
      0: begin send_aw(addr); tick(gap); send_w(data, strb); end
      1: begin send_w(data, strb); tick(gap); send_aw(addr); end
      default: begin
        u_axi.awaddr = addr; u_axi.awvalid = 1'b1;
        u_axi.wdata = data; u_axi.wstrb = strb; u_axi.wvalid = 1'b1;
        while ((u_axi.awvalid || u_axi.wvalid) && cnt < 50) begin
          a_rdy = u_axi.awready; w_rdy = u_axi.wready;
          tick(1); cnt++;
          if (a_rdy) u_axi.awvalid = 1'b0;
          if (w_rdy) u_axi.wvalid = 1'b0;
        end
        if (u_axi.awvalid || u_axi.wvalid) begin
          n_total++; $display("FAIL aw_w_timeout: awvalid=%b wvalid=%b still pending", u_axi.awvalid, u_axi.wvalid);
          u_axi.awvalid = 1'b0; u_axi.wvalid = 1'b0;
        end
      end
    endcase
    wait_b(resp, p0, p1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output logic lat_ok);
    int cnt = 0;
    send_ar(addr);
    lat_ok = u_axi.rvalid;
    while (!u_axi.rvalid && cnt < 50) begin tick(1); cnt++; end
    u_axi.rready = 1'b1;
    data = u_axi.rdata;
    resp = u_axi.rresp;
    tick(1);
    u_axi.rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d, ed; logic [1:0] r, er; logic lat;
    #2 rst_n = 1'b0;
    tick(2);
    n_total++; if (ctrl !== RST) $display("FAIL rst_ctrl: got %h, required %h", ctrl, RST); else n_pass++;
    n_total++; if ({u_axi.bvalid, u_axi.rvalid, pulse} !== '0) $display("FAIL rst_valids: bvalid=%b rvalid=%b pulse=%b, required all 0", u_axi.bvalid, u_axi.rvalid, pulse); else n_pass++;
    n_total++; if (u_axi.rdata !== 32'h0) $display("FAIL rst_rdata: got %h, required 0", u_axi.rdata); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    m_reset();
    n_total++; if ({u_axi.awready, u_axi.wready, u_axi.arready} !== 3'b111) $display("FAIL rst_readies: got %b, required 111", {u_axi.awready, u_axi.wready, u_axi.arready}); else n_pass++;
    status = {$urandom, $urandom};
    for (int i = 0; i < RW + RO; i++) begin
      m_read(BASE + 32'(4 * i), ed, er);
      do_read(BASE + 32'(4 * i), d, r, lat);
      n_total++; if (d !== ed || r !== er) $display("FAIL rst_readback[%0d]: got %h/%b, required %h/%b", i, d, r, ed, er); else n_pass++;
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d, ed; logic [1:0] r, er, eresp; logic lat; logic [RW-1:0] p0, p1, pe;
    eresp = m_write(BASE + 4, 32'hA5A5_0001, 4'hF, pe);
    do_write(BASE + 4, 32'hA5A5_0001, 4'hF, 1, 3, r, p0, p1);
    n_total++; if (r !== eresp) $display("FAIL wfirst_bresp: got %b, required %b", r, eresp); else n_pass++;
    n_total++; if (p0 !== pe || p1 !== '0) $display("FAIL wfirst_pulse: got %b then %b, required %b then 0", p0, p1, pe); else n_pass++;
    tick(3);
    n_total++; if (u_axi.bvalid !== 1'b0) $display("FAIL wfirst_single_b: bvalid=%b, required 0", u_axi.bvalid); else n_pass++;
    m_read(BASE + 4, ed, er);
    do_read(BASE + 4, d, r, lat);
    n_total++; if (d !== ed || r !== er) $display("FAIL wfirst_readback: got %h/%b, required %h/%b", d, r, ed, er); else n_pass++;
  endtask

  task automatic test_strobe();
    logic [31:0] d, ed; logic [1:0] r, er, eresp; logic lat; logic [RW-1:0] p0, p1, pe;
    eresp = m_write(BASE, 32'h1122_3344, 4'hF, pe);
    do_write(BASE, 32'h1122_3344, 4'hF, 2, 0, r, p0, p1);
    eresp = m_write(BASE, 32'h0000_BB00, 4'b0010, pe);
    do_write(BASE, 32'h0000_BB00, 4'b0010, 0, 0, r, p0, p1);
    n_total++; if (r !== eresp || p0 !== pe) $display("FAIL strb_partial_resp: got %b/%b, required %b/%b", r, p0, eresp, pe); else n_pass++;
    m_read(BASE, ed, er);
    do_read(BASE, d, r, lat);
    n_total++; if (d !== ed) $display("FAIL strb_merge: got %h, required %h", d, ed); else n_pass++;
    eresp = m_write(BASE, 32'hFFFF_FFFF, 4'h0, pe);
    do_write(BASE, 32'hFFFF_FFFF, 4'h0, 1, 1, r, p0, p1);
    n_total++; if (r !== eresp || p0 !== pe) $display("FAIL strb_zero: got resp %b pulse %b, required %b/%b", r, p0, eresp, pe); else n_pass++;
    do_read(BASE, d, r, lat);
    n_total++; if (d !== ed) $display("FAIL strb_zero_nochange: got %h, required %h", d, ed); else n_pass++;
  endtask

  task automatic test_slverr();
    logic [31:0] d, ed; logic [1:0] r, er, eresp; logic lat; logic [RW-1:0] p0, p1, pe;
    logic [31:0] addrs [3];
    addrs[0] = BASE + 32'(4 * RW); addrs[1] = BASE + 32'h100; addrs[2] = BASE - 4;
    for (int k = 0; k < 3; k++) begin
      eresp = m_write(addrs[k], 32'hFFFF_FFFF, 4'hF, pe);
      do_write(addrs[k], 32'hFFFF_FFFF, 4'hF, k, 1, r, p0, p1);
      n_total++; if (r !== eresp || p0 !== pe) $display("FAIL slverr_write[%0d]: got %b/%b, required %b/%b", k, r, p0, eresp, pe); else n_pass++;
    end
    for (int i = 0; i < RW; i++) begin
      m_read(BASE + 32'(4 * i), ed, er);
      do_read(BASE + 32'(4 * i), d, r, lat);
      n_total++; if (d !== ed) $display("FAIL slverr_nochange[%0d]: got %h, required %h", i, d, ed); else n_pass++;
    end
    m_read(BASE + 32'h100, ed, er);
    do_read(BASE + 32'h100, d, r, lat);
    n_total++; if (d !== ed || r !== er) $display("FAIL unmapped_read: got %h/%b, required %h/%b", d, r, ed, er); else n_pass++;
  endtask

  task automatic test_shadow();
    logic [1:0] r, eresp; logic [RW-1:0] p0, p1, pe;
    n_total++; if (ctrl !== m_ctrl_packed()) $display("FAIL shadow_initial: got %h, required %h", ctrl, m_ctrl_packed()); else n_pass++;
    send_aw(BASE + 8);
    send_w(32'h0000_0007, 4'hF);
    upd = 1'b1;                       // lands on the commit edge
    tick(1);
    upd = 1'b0;
    m_update();
    eresp = m_write(BASE + 8, 32'h0000_0007, 4'hF, pe);
    wait_b(r, p0, p1);
    n_total++; if (r !== eresp || p0 !== pe) $display("FAIL shadow_commit: got %b/%b, required %b/%b", r, p0, eresp, pe); else n_pass++;
    n_total++; if (ctrl[64 +: 32] !== m_ctrl[2]) $display("FAIL shadow_same_edge: got %h, required %h", ctrl[64 +: 32], m_ctrl[2]); else n_pass++;
    n_total++; if (ctrl !== m_ctrl_packed()) $display("FAIL shadow_all_old: got %h, required %h", ctrl, m_ctrl_packed()); else n_pass++;
    upd = 1'b1; tick(1); upd = 1'b0;
    m_update();
    n_total++; if (ctrl[64 +: 32] !== 32'h0000_0007) $display("FAIL shadow_next_upd: got %h, required 00000007", ctrl[64 +: 32]); else n_pass++;
    n_total++; if (ctrl !== m_ctrl_packed()) $display("FAIL shadow_all_new: got %h, required %h", ctrl, m_ctrl_packed()); else n_pass++;
  endtask

  task automatic test_bready_stall();
    logic [31:0] d, ed, ro_exp; logic [1:0] r, er, wr_exp; logic lat; logic [RW-1:0] p0, p1, pe;
    int bad = 0;
    wr_exp = m_write(BASE + 12, 32'h0BAD_F00D, 4'hF, pe);
    send_aw(BASE + 12);
    send_w(32'h0BAD_F00D, 4'hF);
    tick(1);
    n_total++; if (u_axi.bvalid !== 1'b1 || pulse !== pe) $display("FAIL stall_commit: bvalid=%b pulse=%b, required 1/%b", u_axi.bvalid, pulse, pe); else n_pass++;
    m_read(BASE, ed, er);
    do_read(BASE, d, r, lat);
    n_total++; if (lat !== 1'b1) $display("FAIL stall_read_latency: rvalid after AR=%b, required 1", lat); else n_pass++;
    n_total++; if (d !== ed || r !== er) $display("FAIL stall_read_data: got %h/%b, required %h/%b", d, r, ed, er); else n_pass++;
    // RO read held without rready while the status input moves on
    m_read(BASE + 32'(4 * (RW + 1)), ro_exp, er);
    send_ar(BASE + 32'(4 * (RW + 1)));
    status = {$urandom, $urandom};
    tick(3);
    n_total++; if (u_axi.rvalid !== 1'b1 || u_axi.rdata !== ro_exp) $display("FAIL rvalid_hold: rvalid=%b rdata=%h, required 1/%h", u_axi.rvalid, u_axi.rdata, ro_exp); else n_pass++;
    u_axi.rready = 1'b1; tick(1); u_axi.rready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (u_axi.bvalid !== 1'b1 || u_axi.awready !== 1'b0 || u_axi.wready !== 1'b0 || u_axi.bresp !== wr_exp) bad++;
      tick(1);
    end
    n_total++; if (bad != 0) $display("FAIL stall_hold: %0d bad cycles, required 0", bad); else n_pass++;
    wait_b(r, p0, p1);
    n_total++; if (r !== wr_exp) $display("FAIL stall_bresp: got %b, required %b", r, wr_exp); else n_pass++;
    tick(1);
    n_total++; if ({u_axi.awready, u_axi.wready} !== 2'b11) $display("FAIL stall_release: got %b, required 11", {u_axi.awready, u_axi.wready}); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, dat, d, ed; logic [3:0] s; logic [1:0] r, er, eresp; logic lat;
    logic [RW-1:0] p0, p1, pe;
    int op;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      a  = rand_addr();
      if (op <= 5) begin
        dat = $urandom; s = 4'($urandom_range(0, 15));
        eresp = m_write(a, dat, s, pe);
        do_write(a, dat, s, $urandom_range(0, 2), $urandom_range(0, 3), r, p0, p1);
        n_total++; if (r !== eresp || p0 !== pe || p1 !== '0) $display("FAIL rnd_write[%0d] @%h: got %b/%b/%b, required %b/%b/0", it, a, r, p0, p1, eresp, pe); else n_pass++;
      end else if (op <= 7) begin
        m_read(a, ed, er);
        do_read(a, d, r, lat);
        n_total++; if (d !== ed || r !== er || lat !== 1'b1) $display("FAIL rnd_read[%0d] @%h: got %h/%b lat %b, required %h/%b lat 1", it, a, d, r, lat, ed, er); else n_pass++;
      end else if (op == 8) begin
        upd = 1'b1; tick(1); upd = 1'b0;
        m_update();
      end else begin
        status = {$urandom, $urandom};
        tick(1);
      end
      n_total++; if (ctrl !== m_ctrl_packed()) $display("FAIL rnd_ctrl[%0d]: got %h, required %h", it, ctrl, m_ctrl_packed()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; logic lat;
    int seen_b = 0;
    send_aw(BASE + 4);
    rst_n = 1'b0;
    #1;
    n_total++; if (ctrl !== RST) $display("FAIL midrst_ctrl_async: got %h, required %h", ctrl, RST); else n_pass++;
    tick(1);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    m_reset();
    n_total++; if (u_axi.awready !== 1'b1) $display("FAIL midrst_aw_dropped: awready=%b, required 1", u_axi.awready); else n_pass++;
    send_w(32'hFFFF_FFFF, 4'hF);
    for (int c = 0; c < 6; c++) begin
      if (u_axi.bvalid !== 1'b0 || pulse !== '0) seen_b++;
      tick(1);
    end
    n_total++; if (seen_b != 0) $display("FAIL midrst_no_commit: %0d cycles with bvalid/pulse, required 0", seen_b); else n_pass++;
    n_total++; if (ctrl !== m_ctrl_packed()) $display("FAIL midrst_ctrl: got %h, required %h", ctrl, m_ctrl_packed()); else n_pass++;
    do_read(BASE + 4, d, r, lat);
    n_total++; if (d !== m_stage[1]) $display("FAIL midrst_stage: got %h, required %h", d, m_stage[1]); else n_pass++;
    rst_n = 1'b0; tick(1);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    n_total++; if ({u_axi.awready, u_axi.wready, u_axi.arready} !== 3'b111) $display("FAIL midrst_clean: got %b, required 111", {u_axi.awready, u_axi.wready, u_axi.arready}); else n_pass++;
  endtask

  initial begin
    u_axi.awaddr = '0; u_axi.awvalid = 1'b0;
    u_axi.wdata = '0; u_axi.wstrb = '0; u_axi.wvalid = 1'b0;
    u_axi.bready = 1'b0;
    u_axi.araddr = '0; u_axi.arvalid = 1'b0; u_axi.rready = 1'b0;
    m_reset();
    test_reset();
    test_w_before_aw();
    test_strobe();
    test_slverr();
    test_shadow();
    test_bready_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
